// File: rtl/dac_buf_pkg.sv
// Shared sizing constants and lane-decode helper for the DAC sample buffer.
package dac_buf_pkg;

   localparam int WR_AW_DEF = 11;
   localparam int WR_DW_DEF = 8;
   localparam int RD_AW_DEF = 9;
   localparam int RD_DW_DEF = 32;
   localparam int LANES     = 4;
   localparam int LANE_W    = 2;

   function automatic logic lane_sel(input logic [LANE_W-1:0] byte_lsb,
                                     input logic [LANE_W-1:0] lane);
      return byte_lsb == lane;
   endfunction

endpackage

// File: rtl/dac_buf_bank.sv
// One byte lane of the sample buffer: simple dual-port RAM with a registered read.
// The read register is cleared asynchronously; the array itself is never reset.
module dac_buf_bank #(
   parameter int AW = 9,
   parameter int DW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wren,
   input  logic [AW-1:0] wraddress,
   input  logic [DW-1:0] data,
   input  logic [AW-1:0] rdaddress,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clock) begin
      if (wren) begin
         mem[wraddress] <= data;
      end
   end

   // Nonblocking update means a same-edge read sees the pre-write byte.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= mem[rdaddress];
      end
   end

endmodule

// File: rtl/dac_buf.sv
// Audio sample buffer: byte-wide MCU write port, 32-bit stereo-word DAC read port.
// Define DAC_BUF_OUTREG_EN to add an output pipeline register (read latency 2).
module dac_buf
   import dac_buf_pkg::*;
#(
   parameter int WR_AW = WR_AW_DEF,
   parameter int WR_DW = WR_DW_DEF,
   parameter int RD_AW = RD_AW_DEF,
   parameter int RD_DW = RD_DW_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wren,
   input  logic [WR_AW-1:0] wraddress,
   input  logic [WR_DW-1:0] data,
   input  logic [RD_AW-1:0] rdaddress,
   output logic [RD_DW-1:0] q
);

   logic [RD_DW-1:0] ram_q;
   logic [LANES-1:0] lane_wren;

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      assign lane_wren[n] = wren & lane_sel(wraddress[LANE_W-1:0], LANE_W'(n));

      dac_buf_bank #(
         .AW (RD_AW),
         .DW (WR_DW)
      ) u_bank (
         .clock     (clock),
         .reset     (reset),
         .wren      (lane_wren[n]),
         .wraddress (wraddress[WR_AW-1:LANE_W]),
         .data      (data),
         .rdaddress (rdaddress),
         .q         (ram_q[n*WR_DW +: WR_DW])
      );
   end

`ifdef DAC_BUF_OUTREG_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= ram_q;
      end
   end
`else
   assign q = ram_q;
`endif

endmodule

// File: tb/tb_dac_buf.sv
// Self-checking bench for dac_buf: directed scenarios followed by random traffic,
// all checked against a byte-array reference model with an explicit latency pipe.
module tb_dac_buf;

`ifdef DAC_BUF_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wren = 1'b0;
   logic [10:0] wraddress = '0;
   logic [7:0]  data = '0;
   logic [8:0]  rdaddress = '0;
   logic [31:0] q;

   logic [7:0]  ref_mem [2048];
   logic [31:0] pipe [2];
   int          total = 0;
   int          bad = 0;

   logic [10:0] r_wa;
   logic [7:0]  r_d;
   logic [8:0]  r_ra;
   logic        r_we;

   dac_buf u_dut (
      .clock     (clock),
      .reset     (reset),
      .wren      (wren),
      .wraddress (wraddress),
      .data      (data),
      .rdaddress (rdaddress),
      .q         (q)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ref_word(input int w);
      return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
   endfunction

   task automatic check(input string tag, input logic [31:0] exp);
      total++;
      assert (q === exp)
      else begin
         bad++;
         $error("FAIL %s q=%h expected=%h", tag, q, exp);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare just after it.
   task automatic step(input string tag, input logic we, input logic [10:0] wa,
                       input logic [7:0] d, input logic [8:0] ra);
      wren      = we;
      wraddress = wa;
      data      = d;
      rdaddress = ra;
      @(posedge clock);
      if (reset) begin
         pipe[0] = '0;
         pipe[1] = '0;
      end else begin
         pipe[1] = pipe[0];
         pipe[0] = ref_word(int'(ra));
      end
      if (we) ref_mem[int'(wa)] = d;
      #1;
      check(tag, pipe[LAT-1]);
   endtask

   task automatic idle(input string tag, input logic [8:0] ra);
      step(tag, 1'b0, 11'd0, 8'd0, ra);
   endtask

   task automatic pulse_reset();
      reset   = 1'b1;
      pipe[0] = '0;
      pipe[1] = '0;
      #1;
      check("rst_async", 32'h0);
      step("rst_hold", 1'b0, 11'd0, 8'd0, 9'd0);
      reset = 1'b0;
      #1;
      check("rst_release", 32'h0);
   endtask

   initial begin
      pipe[0] = '0;
      pipe[1] = '0;
      for (int i = 0; i < 2048; i++) ref_mem[i] = '0;

      // Reset asserted from time zero: output must already be clear before any edge.
      #1;
      check("rst_init", 32'h0);

      // Zero-fill the array while reset is held; writes must still land, q stays 0.
      for (int i = 0; i < 2048; i++) begin
         step("fill_in_reset", 1'b1, 11'(i), 8'h00, 9'(i >> 2));
      end
      reset = 1'b0;

      // Basic little-endian word assembly.
      step("wr_b0", 1'b1, 11'd0, 8'h11, 9'd0);
      step("wr_b1", 1'b1, 11'd1, 8'h22, 9'd0);
      step("wr_b2", 1'b1, 11'd2, 8'h33, 9'd0);
      step("wr_b3", 1'b1, 11'd3, 8'h44, 9'd0);
      repeat (LAT) idle("rd_w0", 9'd0);
      check("word0_const", 32'h44332211);

      // Lane isolation.
      step("wr_b6", 1'b1, 11'd6, 8'hAA, 9'd1);
      repeat (LAT) idle("rd_w1", 9'd1);
      check("word1_const", 32'h00AA0000);
      repeat (LAT) idle("rd_w0_again", 9'd0);
      check("word0_unchanged", 32'h44332211);

      // Read-during-write to the same word returns the old content.
      step("rdw_same", 1'b1, 11'd0, 8'h55, 9'd0);
      repeat (LAT - 1) idle("rdw_pipe", 9'd0);
      check("rdw_old", 32'h44332211);
      idle("rdw_next", 9'd0);
      check("rdw_new", 32'h44332255);

      // Top word of the address space.
      step("wr_2044", 1'b1, 11'd2044, 8'hDE, 9'd511);
      step("wr_2045", 1'b1, 11'd2045, 8'hAD, 9'd511);
      step("wr_2046", 1'b1, 11'd2046, 8'hBE, 9'd511);
      step("wr_2047", 1'b1, 11'd2047, 8'hEF, 9'd511);
      repeat (LAT) idle("rd_w511", 9'd511);
      check("word511_const", 32'hEFBEADDE);

      // Mid-run reset leaves the array intact.
      pulse_reset();
      repeat (LAT) idle("post_rst_rd", 9'd0);
      check("post_rst_word0", 32'h44332255);

      // Random traffic with frequent same-word collisions and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            pulse_reset();
         end else begin
            r_we = 1'($urandom_range(0, 1));
            r_wa = 11'($urandom);
            r_d  = 8'($urandom);
            r_ra = ($urandom_range(0, 2) == 0) ? r_wa[10:2] : 9'($urandom);
            step("random", r_we, r_wa, r_d, r_ra);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
